// File: rtl/jk_reg_array.sv
// rtl/jk_reg_array.sv - WIDTH-bit register of JK cells with count, shift and load modes
//
// Every bit is a JK cell. The mode selects where each cell's J/K come from:
// the per-bit j/k inputs, an up/down carry chain, or a shift pattern.
// load bypasses the cells; rst dominates everything.
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   rst   - synchronous active-high reset (q=RST_VAL, tc=0, chg=0)
//   en    - update enable; low holds q (load still acts)
//   mode  - 00 JK per bit, 01 count up, 10 count down, 11 shift left
//   load  - parallel load of d; overrides en and mode
//   d     - parallel load data
//   j, k  - per-bit J/K in mode 00; j[0] is the serial input in mode 11
//   q     - register state
//   qb    - ~q, derived from q
//   tc    - registered wrap / shifted-out-one flag
//   chg   - registered flag: q changed on the last edge

module jk_reg_array #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             chg
);

    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_UP    = 2'b01;
    localparam logic [1:0] MODE_DOWN  = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             chg_r;

    // up_t[i]  = AND of q[i-1:0]  : bit i toggles when counting up
    // dn_t[i]  = AND of ~q[i-1:0] : bit i toggles when counting down
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] q_jk;
    logic [WIDTH-1:0] q_next;
    logic             tc_mode;
    logic             tc_next;
    logic             chg_next;

    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q_r[i-1];
            dn_t[i] = dn_t[i-1] & ~q_r[i-1];
        end
    end

    assign shifted = {q_r[WIDTH-2:0], j[0]};

    // Select J/K drive for every cell, and the wrap condition of the mode.
    always_comb begin
        jv      = '0;
        kv      = '0;
        tc_mode = 1'b0;
        case (mode)
            MODE_JK: begin
                jv = j;
                kv = k;
            end
            MODE_UP: begin
                jv      = up_t;
                kv      = up_t;
                tc_mode = &q_r;
            end
            MODE_DOWN: begin
                jv      = dn_t;
                kv      = dn_t;
                tc_mode = ~|q_r;
            end
            MODE_SHIFT: begin
                // J=s, K=~s forces each cell to the shifted-in value.
                jv      = shifted;
                kv      = ~shifted;
                tc_mode = q_r[WIDTH-1];
            end
            default: begin
                jv      = '0;
                kv      = '0;
                tc_mode = 1'b0;
            end
        endcase
    end

    // JK characteristic equation: Q+ = J.~Q + ~K.Q
    assign q_jk = (jv & ~q_r) | (~kv & q_r);

    always_comb begin
        q_next  = q_r;
        tc_next = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en) begin
            q_next  = q_jk;
            tc_next = tc_mode;
        end
        chg_next = (q_next != q_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= RST_VAL;
            tc_r  <= 1'b0;
            chg_r <= 1'b0;
        end else begin
            q_r   <= q_next;
            tc_r  <= tc_next;
            chg_r <= chg_next;
        end
    end

    assign q   = q_r;
    assign qb  = ~q_r;
    assign tc  = tc_r;
    assign chg = chg_r;

endmodule

// File: doc/jk_reg_array.md
# jk_reg_array

Parametrised WIDTH-bit register built from JK cells, the multi-bit successor to our single-bit JK flip-flop. Each bit obeys JK semantics with per-bit J/K inputs. Mode-selectable synchronous up/down counting and serial shift are added. A parallel load, a wrap flag and a change flag let the block act as a general state or counter element in the datapath.

## Interface
- WIDTH, 8, number of JK cells (≥2)
- RST_VAL, {WIDTH{1'b0}}, value of q after reset
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  update enable; low holds q (load still acts)
- mode  input  2  00 JK-per-bit, 01 count up, 10 count down, 11 shift left
- load  input  1  parallel load of d (overrides mode/en)
- d  input  WIDTH  parallel load data
- j  input  WIDTH  per-bit J (mode 00); j[0] is serial-in (mode 11)
- k  input  WIDTH  per-bit K (mode 00); ignored in other modes
- q  output  WIDTH  register state
- qb  output  WIDTH  always exactly ~q
- tc  output  1  wrap flag, registered
- chg  output  1  q changed on last edge, registered

## Operation
- Reset: on a rising edge with rst=1, q=RST_VAL, qb=~RST_VAL, tc=0, chg=0. rst dominates all other inputs.
- Priority per edge: rst > load > en.
- load=1 sets q=d regardless of en/mode. tc=0. chg=(d!=q_old).
- en=0, load=0: q holds, tc=0, chg=0.
- en=1, mode 00, per bit i:
  - j=0,k=0: hold.
  - j=0,k=1: q[i]=0.
  - j=1,k=0: q[i]=1.
  - j=1,k=1: q[i]=~q[i].
- en=1, mode 01: q=q+1 mod 2^WIDTH. Realised as a JK chain: J=K=1 for bit 0; J=K=AND(q[i-1:0]) for bit i.
  - tc=1 if q_old was all-ones (wrap to 0), else 0.
- en=1, mode 10: q=q-1 mod 2^WIDTH. Uses J=K=AND(~q[i-1:0]).
  - tc=1 if q_old was all-zeros (wrap to all-ones), else 0.
- en=1, mode 11: q={q[WIDTH-2:0], j[0]}. tc=1 if the shifted-out bit q_old[WIDTH-1] was 1.
- tc=0 in mode 00.
- chg=1 iff new q != q_old, for any cause except reset.
- qb is derived from the registered q, never stored separately. qb!=~q is a bug.
- Mode changes take effect on the same edge they are sampled. No intermediate state.

## Timing
- All outputs are registered. Inputs sampled at edge N are visible in q/qb/tc/chg after edge N.
- Latency is 1 cycle, and throughput is one update per cycle.
- No combinational path from inputs to outputs.
- tc and chg are single-cycle pulses per qualifying edge. Back-to-back wraps, e.g. WIDTH=2 continuously counting, give tc high on every wrapping edge.
- Reset asserted mid-count forces the reset values on that edge. The first count after rst deasserts starts from RST_VAL.
- Simultaneous load and rst: reset wins. Simultaneous load and en: load wins, and tc=0.

## Test plan
- WIDTH=4, RST_VAL=4'hA:
  - rst=1 for 2 cycles -> q=4'hA, qb=4'h5, tc=0, chg=0.
  - Release rst with en=0 for 3 cycles -> q stays 4'hA, chg=0.
- Mode 00, q=4'b1010, j=4'b0011, k=4'b0101 -> q=4'b1011: bit3 hold, bit2 reset, bit1 set, bit0 toggle. qb=4'b0100, chg=1.
  - Repeat with j=k=0 -> q unchanged, chg=0.
- Mode 01 from load d=4'hE:
  - Edge 1: q=4'hF, tc=0.
  - Edge 2: q=4'h0, tc=1.
  - Edge 3: q=4'h1, tc=0.
  - Drop en for one cycle mid-count -> q holds, tc=0.
- Mode 10 from q=4'h1:
  - Edge 1: q=4'h0, tc=0.
  - Edge 2: q=4'hF, tc=1.
  - Switch to mode 01 on the next edge -> q=4'h0, tc=1.
- Mode 11, q=4'b1001, j[0] sequence 1,0,0:
  - Edge 1: q=4'b0011, tc=1.
  - Edge 2: q=4'b0110, tc=0.
  - Edge 3: q=4'b1100, tc=0.
- Priority check:
  - load=1, d=4'h3, en=1, mode=01 -> q=4'h3, tc=0.
  - Next edge rst=1, load=1, d=4'h7 -> q=4'hA, qb=4'h5, tc=0, chg=0.
- Every cycle of every test: assert qb==~q.
